mdu_multicycle: RTL

- Iterative multiply/divide unit with HI/LO result registers for the multicycle processor datapath.
- Executes MULT, MULTU, DIV and DIVU at one bit per clock behind a Start/Busy/Done handshake.
- The main control FSM stalls on Busy.
- Parametrised in data width (DWL); supports direct HI/LO writes (MTHI/MTLO).

---
 rtl/mdu_multicycle.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/mdu_multicycle.sv
// Iterative multiply/divide unit with HI/LO result registers.
// MULT/MULTU use shift-add and DIV/DIVU use restoring division, one bit per clock.
module mdu_multicycle #(
  parameter int DWL = 32,
  parameter int CW  = $clog2(DWL)
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           Start,
  input  logic [1:0]     Op,
  input  logic [DWL-1:0] A,
  input  logic [DWL-1:0] B,
  input  logic           HiWE,
  input  logic           LoWE,
  input  logic [DWL-1:0] WD,
  output logic           Busy,
  output logic           Done,
  output logic           DivZero,
  output logic [DWL-1:0] Hi,
  output logic [DWL-1:0] Lo
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t         state_q, state_d;
  logic [1:0]     op_q, op_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [DWL:0]   dvs_q, dvs_d;
  logic [DWL-1:0] rem_q, rem_d;
  logic [DWL-1:0] quo_q, quo_d;
  logic [DWL-1:0] hi_q, hi_d;
  logic [DWL-1:0] lo_q, lo_d;
  logic           neg_q, neg_d;
  logic           aneg_q, aneg_d;
  logic           dz_q, dz_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           divzero_q, divzero_d;

  logic [DWL:0]     sum;
  logic [DWL:0]     shifted;
  logic [DWL-1:0]   diff;
  logic [2*DWL-1:0] prod;
  logic             sgn_op;

  // Magnitude on DWL+1 bits so that the most negative value stays representable.
  function automatic logic [DWL:0] magnitude(input logic signed [DWL-1:0] v,
                                             input logic sgn);
    logic signed [DWL:0] ext;
    ext = $signed({v[DWL-1], v});
    if (sgn && v[DWL-1])
      magnitude = $unsigned(-ext);
    else
      magnitude = {1'b0, v};
  endfunction

  function automatic logic [DWL-1:0] apply_sign(input logic [DWL-1:0] v, input logic neg);
    apply_sign = neg ? $unsigned(-$signed(v)) : v;
  endfunction

  function automatic logic [2*DWL-1:0] apply_sign2(input logic [2*DWL-1:0] v, input logic neg);
    apply_sign2 = neg ? $unsigned(-$signed(v)) : v;
  endfunction

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    dvs_d     = dvs_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    neg_d     = neg_q;
    aneg_d    = aneg_q;
    dz_d      = dz_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    divzero_d = 1'b0;
    sum       = {1'b0, rem_q} + (quo_q[0] ? dvs_q : '0);
    shifted   = {rem_q, quo_q[DWL-1]};
    diff      = shifted[DWL-1:0] - dvs_q[DWL-1:0];
    prod      = '0;
    sgn_op    = ~op_q[0];

    case (state_q)
      IDLE: begin
        if (Start) begin
          op_d    = Op;
          neg_d   = A[DWL-1] ^ B[DWL-1];
          aneg_d  = A[DWL-1];
          dz_d    = Op[1] & (B == '0);
          rem_d   = '0;
          cnt_d   = CW'(DWL - 1);
          busy_d  = 1'b1;
          state_d = CALC;
          // Divide keeps the dividend in quo; multiply keeps the multiplier there.
          if (Op[1]) begin
            quo_d = DWL'(magnitude(A, ~Op[0]));
            dvs_d = magnitude(B, ~Op[0]);
          end else begin
            quo_d = DWL'(magnitude(B, ~Op[0]));
            dvs_d = magnitude(A, ~Op[0]);
          end
        end else begin
          if (HiWE) hi_d = WD;
          if (LoWE) lo_d = WD;
        end
      end

      CALC: begin
        if (op_q[1]) begin
          if (shifted >= dvs_q) begin
            rem_d = diff;
            quo_d = {quo_q[DWL-2:0], 1'b1};
          end else begin
            rem_d = shifted[DWL-1:0];
            quo_d = {quo_q[DWL-2:0], 1'b0};
          end
        end else begin
          rem_d = sum[DWL:1];
          quo_d = {sum[0], quo_q[DWL-1:1]};
        end
        if (cnt_q == '0) state_d = FIX;
        else             cnt_d   = cnt_q - CW'(1);
      end

      FIX: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        // On divide-by-zero the remainder is |A| re-signed, i.e. A itself.
        if (op_q[1]) begin
          lo_d      = apply_sign(quo_q, sgn_op & neg_q & ~dz_q);
          hi_d      = apply_sign(rem_q, sgn_op & aneg_q);
          divzero_d = dz_q;
        end else begin
          prod = apply_sign2({rem_q, quo_q}, sgn_op & neg_q);
          hi_d = prod[2*DWL-1:DWL];
          lo_d = prod[DWL-1:0];
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      op_q      <= '0;
      cnt_q     <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      neg_q     <= 1'b0;
      aneg_q    <= 1'b0;
      dz_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      divzero_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      cnt_q     <= cnt_d;
      dvs_q     <= dvs_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      neg_q     <= neg_d;
      aneg_q    <= aneg_d;
      dz_q      <= dz_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      divzero_q <= divzero_d;
    end
  end

  assign Busy    = busy_q;
  assign Done    = done_q;
  assign DivZero = divzero_q;
  assign Hi      = hi_q;
  assign Lo      = lo_q;

endmodule
